win_check_sequencer: RTL and testbench
======================================

Name: win_check_sequencer

Overview:
- Sequences the combinational board read mux after each placed stone. It drives the 8-bit xy select, walks outward from the last move along 4 axes, and counts contiguous same-colour stones.
- Reports whether the move completed five (or more) in a row.
- Sits between the game-control FSM (start/done) and the board read mux (rd_select/rd_data).

Parameters:
- WIN_LEN, 5, contiguous stones required for a win (2..8).
- BOARD_BITS, 4, bits per coordinate; board is 2^BOARD_BITS square (16x16).

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- move_xy  in  8  last move; [7:4]=x, [3:0]=y
- player  in  2  colour just placed (01 or 10)
- rd_select  out  8  xy to board read mux; [7:4]=x, [3:0]=y
- rd_data  in  2  cell contents for rd_select; combinational, same cycle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, result valid
- win  out  1  move completed >= WIN_LEN in a row
- win_dir  out  2  axis of win: 0=(0,+1), 1=(+1,0), 2=(+1,+1), 3=(+1,-1)

Behaviour:
- Reset (async, resetn=0) clears all outputs to 0 and forces state to IDLE. This holds at any time, including mid-scan; no partial result is reported.
- Cell encoding: 00 empty, 01 player 1, 10 player 2, 11 invalid (never matches).
- States:
  - IDLE: on start=1, latch move_xy/player, set busy=1, dir=0, side=+, count=1, clear win/win_dir.
    - If player is 00 or 11, go to DONE with win=0.
    - Otherwise go to SETUP.
  - SETUP (1 cycle): compute first probe = origin + sign*delta[dir] in 5-bit signed per coordinate.
    - If either coordinate is outside 0..15, the side ends; no wrap-around is allowed (x=15 +1 is off-board, not 0).
    - Else register rd_select=probe and go to PROBE.
  - PROBE (1 cycle per cell): compare rd_data with latched player.
    - Match: count++. If count==WIN_LEN, set win=1, win_dir=dir, and go to DONE (early exit). Else step the probe; if the next probe is off-board, the side ends, otherwise stay in PROBE.
    - Mismatch: the side ends.
  - Side end:
    - If side=+, switch to side=- and go to SETUP.
    - If side=-, go to NEXT.
  - NEXT: if dir==3, go to DONE with win=0. Else dir++, side=+, count=1, go to SETUP.
  - DONE: done=1 for exactly one cycle, busy=0 on the following edge, return to IDLE. win/win_dir hold until the next accepted start.
- Count width is 4 bits and saturates at WIN_LEN; more than WIN_LEN stones still reports win.
- The origin cell is never read; it is counted as 1.
- rd_select holds its last value when idle (reset value 0x00).
- Latency: done asserts no later than 4*2*(1+WIN_LEN-1)+2 = 42 cycles after start (WIN_LEN=5). Non-win worst case ≈ 34 cycles.
- start while busy is ignored, with no queueing. start coincident with done is ignored.
- move_xy/player changes after acceptance have no effect.

Decomposition:
- Shared package gobang_pkg holds:
  - cell codes EMPTY=2'b00, P1=2'b01, P2=2'b10
  - direction codes DIR_H..DIR_AD
  - per-direction dx/dy delta table
  - state encoding for this FSM
- One natural sub-module: coord_stepper. It is combinational: takes xy, dir, and side; returns next xy plus an off_board flag. It is reused by the future AI move evaluator.

Test Plan:
- Row win: stones P1 at x=7, y=3..7; start move_xy=0x75, player=01 -> done within 42 cycles, win=1, win_dir=0. rd_select never leaves x=7 during dir 0.
- Edge, no wrap: P1 at (0,0),(1,1),(2,2),(3,3) plus P1 at (15,15); start move_xy=0x00 -> win=0. rd_select never equals 0xFF via wrap on the - side of dir 2.
- Anti-diagonal win: P2 at (4,10),(5,9),(6,8),(7,7),(8,6); move_xy=0x68, player=10 -> win=1, win_dir=3.
- Four-only plus blocked: P1 at y=2..5 in row x=9, P2 at (9,6); move 0x93 -> win=0, done pulse width exactly 1, busy low next cycle.
- Invalid player=00 -> done 1 cycle after the SETUP-equivalent (cycle 2), win=0, no PROBE state entered. Repeat start during busy -> ignored, single done.
- Async resetn low mid-PROBE -> busy/done/win/rd_select immediately 0. Fresh start after release completes normally.

Source files
------------

// File: rtl/gobang_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gobang_pkg
//  Description : Shared definitions for the gobang board logic: cell codes,
//                scan-axis codes with their per-axis step table, and the
//                state encoding of the win-check sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package gobang_pkg;

    // Cell contents as returned by the board read mux
    localparam logic [1:0] EMPTY   = 2'b00;
    localparam logic [1:0] P1      = 2'b01;
    localparam logic [1:0] P2      = 2'b10;
    localparam logic [1:0] INVALID = 2'b11;

    // Scan axes; the step for each is given by delta_x/delta_y below
    typedef enum logic [1:0] {
        DIR_H  = 2'd0,      // (0,+1)  along y
        DIR_V  = 2'd1,      // (+1,0)  along x
        DIR_D  = 2'd2,      // (+1,+1) diagonal
        DIR_AD = 2'd3       // (+1,-1) anti-diagonal
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PROBE = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } wcs_state_t;

    function automatic logic signed [1:0] delta_x(input logic [1:0] dir);
        case (dir)
            2'd0:    delta_x = 2'sd0;
            default: delta_x = 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] delta_y(input logic [1:0] dir);
        case (dir)
            2'd0:    delta_y = 2'sd1;
            2'd1:    delta_y = 2'sd0;
            2'd2:    delta_y = 2'sd1;
            default: delta_y = -2'sd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/coord_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : coord_stepper
//  Description : Combinational one-cell step on the board along a scan axis.
//                Each coordinate is widened by one bit and stepped as a
//                signed value, so stepping past either edge is flagged as
//                off-board rather than wrapping.
//  Ports       : xy        - current cell, [2B-1:B]=x, [B-1:0]=y
//                dir       - scan axis (see gobang_pkg::dir_t)
//                side      - 0 = step +delta, 1 = step -delta
//                next_xy   - stepped cell (meaningless when off_board)
//                off_board - stepped cell lies outside the board
//  Revision    : 1.0 - initial release
// ============================================================================
module coord_stepper
    import gobang_pkg::*;
#(
    parameter int BOARD_BITS = 4
) (
    input  logic [2*BOARD_BITS-1:0] xy,
    input  logic [1:0]              dir,
    input  logic                    side,
    output logic [2*BOARD_BITS-1:0] next_xy,
    output logic                    off_board
);

    logic signed [1:0]          dx_raw, dy_raw;
    logic signed [BOARD_BITS:0] dx, dy, nx, ny;

    always_comb begin
        dx_raw = delta_x(dir);
        dy_raw = delta_y(dir);
        dx     = {{(BOARD_BITS-1){dx_raw[1]}}, dx_raw};
        dy     = {{(BOARD_BITS-1){dy_raw[1]}}, dy_raw};
        if (side) begin
            dx = -dx;
            dy = -dy;
        end
        nx = $signed({1'b0, xy[2*BOARD_BITS-1:BOARD_BITS]}) + dx;
        ny = $signed({1'b0, xy[BOARD_BITS-1:0]}) + dy;
        // Results span -1..2^B; both extremes set the extra top bit
        off_board = nx[BOARD_BITS] | ny[BOARD_BITS];
        next_xy   = {nx[BOARD_BITS-1:0], ny[BOARD_BITS-1:0]};
    end

endmodule
`default_nettype wire

// File: rtl/win_check_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : win_check_sequencer
//  Description : After a stone is placed, walks outward from it along four
//                axes through the board read mux, counting contiguous stones
//                of the same colour, and reports whether WIN_LEN in a row
//                were completed.
//  Ports       : clock, resetn     - clock / async active-low reset
//                start             - request, honoured only when idle
//                move_xy, player   - move to evaluate (latched on start)
//                rd_select/rd_data - board read mux address / cell contents
//                busy, done        - in progress / one-cycle completion pulse
//                win, win_dir      - result, held until the next start
//  Revision    : 1.0 - initial release
// ============================================================================
module win_check_sequencer
    import gobang_pkg::*;
#(
    parameter int WIN_LEN    = 5,
    parameter int BOARD_BITS = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [2*BOARD_BITS-1:0] move_xy,
    input  logic [1:0]              player,
    output logic [2*BOARD_BITS-1:0] rd_select,
    input  logic [1:0]              rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    win,
    output logic [1:0]              win_dir
);

    localparam logic [3:0] WIN_CNT = 4'(WIN_LEN);

    wcs_state_t              state, state_nxt;
    logic [2*BOARD_BITS-1:0] origin, origin_nxt;
    logic [2*BOARD_BITS-1:0] rd_select_nxt;
    logic [1:0]              colour, colour_nxt;
    dir_t                    dir, dir_nxt;
    logic                    side, side_nxt;
    logic [3:0]              count, count_nxt, count_inc;
    logic                    busy_nxt, win_nxt;
    logic [1:0]              win_dir_nxt;

    logic [2*BOARD_BITS-1:0] step_base, step_xy;
    logic                    step_off, side_end;

    // SETUP steps from the origin, PROBE steps from the cell just read
    assign step_base = (state == ST_PROBE) ? rd_select : origin;

    coord_stepper #(
        .BOARD_BITS (BOARD_BITS)
    ) u_stepper (
        .xy        (step_base),
        .dir       (dir),
        .side      (side),
        .next_xy   (step_xy),
        .off_board (step_off)
    );

    assign done      = (state == ST_DONE);
    assign count_inc = (count >= WIN_CNT) ? count : count + 4'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            origin    <= '0;
            rd_select <= '0;
            colour    <= EMPTY;
            dir       <= DIR_H;
            side      <= 1'b0;
            count     <= 4'd0;
            busy      <= 1'b0;
            win       <= 1'b0;
            win_dir   <= 2'd0;
        end else begin
            state     <= state_nxt;
            origin    <= origin_nxt;
            rd_select <= rd_select_nxt;
            colour    <= colour_nxt;
            dir       <= dir_nxt;
            side      <= side_nxt;
            count     <= count_nxt;
            busy      <= busy_nxt;
            win       <= win_nxt;
            win_dir   <= win_dir_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        origin_nxt    = origin;
        rd_select_nxt = rd_select;
        colour_nxt    = colour;
        dir_nxt       = dir;
        side_nxt      = side;
        count_nxt     = count;
        busy_nxt      = busy;
        win_nxt       = win;
        win_dir_nxt   = win_dir;
        side_end      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    origin_nxt  = move_xy;
                    colour_nxt  = player;
                    busy_nxt    = 1'b1;
                    dir_nxt     = DIR_H;
                    side_nxt    = 1'b0;
                    count_nxt   = 4'd1;
                    win_nxt     = 1'b0;
                    win_dir_nxt = 2'd0;
                    state_nxt   = (player == P1 || player == P2) ? ST_SETUP : ST_DONE;
                end
            end
            ST_SETUP: begin
                if (step_off) begin
                    side_end = 1'b1;
                end else begin
                    rd_select_nxt = step_xy;
                    state_nxt     = ST_PROBE;
                end
            end
            ST_PROBE: begin
                // colour is always P1/P2 here, so INVALID cells never match
                if (rd_data == colour) begin
                    count_nxt = count_inc;
                    if (count_inc == WIN_CNT) begin
                        win_nxt     = 1'b1;
                        win_dir_nxt = dir;
                        state_nxt   = ST_DONE;
                    end else if (step_off) begin
                        side_end = 1'b1;
                    end else begin
                        rd_select_nxt = step_xy;
                    end
                end else begin
                    side_end = 1'b1;
                end
            end
            ST_NEXT: begin
                if (dir == DIR_AD) begin
                    state_nxt = ST_DONE;
                end else begin
                    dir_nxt   = dir_t'(dir + 2'd1);
                    side_nxt  = 1'b0;
                    count_nxt = 4'd1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Count carries over from the + side to the - side of the same axis
        if (side_end) begin
            if (!side) begin
                side_nxt  = 1'b1;
                state_nxt = ST_SETUP;
            end else begin
                state_nxt = ST_NEXT;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_win_check_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_win_check_sequencer
//  Description : Directed self-checking bench for win_check_sequencer with a
//                behavioural board model behind the read mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_win_check_sequencer;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] move_xy = 8'h00;
    logic [1:0] player  = 2'b00;
    logic [7:0] rd_select;
    logic [1:0] rd_data;
    logic       busy, done, win;
    logic [1:0] win_dir;

    logic [1:0] board [0:255];
    assign rd_data = board[rd_select];

    always #5 clock = ~clock;

    win_check_sequencer #(
        .WIN_LEN    (5),
        .BOARD_BITS (4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .move_xy   (move_xy),
        .player    (player),
        .rd_select (rd_select),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .win       (win),
        .win_dir   (win_dir)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] hist [0:63];
    int         cycles;
    logic       ok;

    task automatic clear_board();
        for (int i = 0; i < 256; i++) board[i] = 2'b00;
    endtask

    task automatic put(input int x, input int y, input logic [1:0] c);
        board[x*16 + y] = c;
    endtask

    // Leaves the bench at the falling edge just after the accepting edge
    task automatic start_move(input logic [7:0] xy, input logic [1:0] p);
        @(negedge clock);
        move_xy = xy;
        player  = p;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
    endtask

    // cycles=1 means done was already high at the first sample after accept
    task automatic wait_done();
        cycles  = 1;
        hist[0] = rd_select;
        while (!done && cycles < 60) begin
            @(negedge clock);
            hist[cycles] = rd_select;
            cycles++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        compared++; if (busy !== 1'b0)      begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (done !== 1'b0)      begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
        compared++; if (win !== 1'b0)       begin mismatched++; $display("FAIL reset_win got %b want 0", win); end
        compared++; if (win_dir !== 2'd0)   begin mismatched++; $display("FAIL reset_win_dir got %0d want 0", win_dir); end
        compared++; if (rd_select !== 8'h00) begin mismatched++; $display("FAIL reset_rd_select got %h want 00", rd_select); end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic load_row();
        clear_board();
        for (int y = 3; y <= 7; y++) put(7, y, 2'b01);
    endtask

    task automatic test_row_win();
        int xbad;
        load_row();
        start_move(8'h75, 2'b01);
        wait_done();
        xbad = 0;
        for (int k = 1; k < cycles; k++) if (hist[k][7:4] != 4'd7) xbad++;
        compared++; if (ok !== 1'b1)     begin mismatched++; $display("FAIL row_done got %b want 1", ok); end
        compared++; if (cycles != 8)     begin mismatched++; $display("FAIL row_latency got %0d want 8", cycles); end
        compared++; if (win !== 1'b1)    begin mismatched++; $display("FAIL row_win got %b want 1", win); end
        compared++; if (win_dir !== 2'd0) begin mismatched++; $display("FAIL row_win_dir got %0d want 0", win_dir); end
        compared++; if (xbad != 0)       begin mismatched++; $display("FAIL row_x_stays got %0d off-row reads want 0", xbad); end
    endtask

    task automatic test_invalid_player();
        logic [7:0] prev;
        prev = rd_select;
        start_move(8'h75, 2'b00);
        wait_done();
        compared++; if (cycles != 1)      begin mismatched++; $display("FAIL invalid_latency got %0d want 1", cycles); end
        compared++; if (win !== 1'b0)     begin mismatched++; $display("FAIL invalid_win got %b want 0", win); end
        compared++; if (rd_select !== prev) begin mismatched++; $display("FAIL invalid_no_probe got %h want %h", rd_select, prev); end
        @(negedge clock);
        compared++; if (busy !== 1'b0)    begin mismatched++; $display("FAIL invalid_busy_after got %b want 0", busy); end
    endtask

    task automatic test_edge_no_wrap();
        int ff_seen;
        clear_board();
        for (int i = 0; i < 4; i++) put(i, i, 2'b01);
        put(15, 15, 2'b01);
        start_move(8'h00, 2'b01);
        wait_done();
        ff_seen = 0;
        for (int k = 0; k < cycles; k++) if (hist[k] == 8'hFF) ff_seen++;
        compared++; if (ok !== 1'b1)  begin mismatched++; $display("FAIL edge_done got %b want 1", ok); end
        compared++; if (win !== 1'b0) begin mismatched++; $display("FAIL edge_win got %b want 0", win); end
        compared++; if (ff_seen != 0) begin mismatched++; $display("FAIL edge_wrap_read got %0d reads of FF want 0", ff_seen); end
    endtask

    task automatic test_anti_diag();
        clear_board();
        put(4, 10, 2'b10); put(5, 9, 2'b10); put(6, 8, 2'b10);
        put(7, 7, 2'b10);  put(8, 6, 2'b10);
        start_move(8'h68, 2'b10);
        wait_done();
        compared++; if (ok !== 1'b1)      begin mismatched++; $display("FAIL anti_done got %b want 1", ok); end
        compared++; if (win !== 1'b1)     begin mismatched++; $display("FAIL anti_win got %b want 1", win); end
        compared++; if (win_dir !== 2'd3) begin mismatched++; $display("FAIL anti_win_dir got %0d want 3", win_dir); end
    endtask

    task automatic test_four_blocked();
        clear_board();
        for (int y = 2; y <= 5; y++) put(9, y, 2'b01);
        put(9, 6, 2'b10);
        start_move(8'h93, 2'b01);
        wait_done();
        compared++; if (ok !== 1'b1)   begin mismatched++; $display("FAIL blocked_done got %b want 1", ok); end
        compared++; if (win !== 1'b0)  begin mismatched++; $display("FAIL blocked_win got %b want 0", win); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL blocked_busy_at_done got %b want 1", busy); end
        @(negedge clock);
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL blocked_done_width got %b want 0", done); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL blocked_busy_after got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int extra;
        load_row();
        start_move(8'h75, 2'b01);
        // Hold a different request high through the run and the done cycle
        move_xy = 8'h00;
        player  = 2'b10;
        start   = 1'b1;
        wait_done();
        compared++; if (ok !== 1'b1)   begin mismatched++; $display("FAIL b2b_done got %b want 1", ok); end
        compared++; if (cycles != 8)   begin mismatched++; $display("FAIL b2b_latency got %0d want 8", cycles); end
        @(negedge clock);
        start = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_start_at_done got busy %b want 0", busy); end
        extra = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clock);
            if (done) extra++;
        end
        compared++; if (extra != 0)       begin mismatched++; $display("FAIL b2b_extra_done got %0d want 0", extra); end
        compared++; if (win !== 1'b1)     begin mismatched++; $display("FAIL b2b_win_hold got %b want 1", win); end
        compared++; if (win_dir !== 2'd0) begin mismatched++; $display("FAIL b2b_win_dir_hold got %0d want 0", win_dir); end
    endtask

    task automatic test_reset_mid_probe();
        load_row();
        start_move(8'h75, 2'b01);
        @(negedge clock);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        compared++; if (busy !== 1'b0)      begin mismatched++; $display("FAIL midrst_busy got %b want 0", busy); end
        compared++; if (done !== 1'b0)      begin mismatched++; $display("FAIL midrst_done got %b want 0", done); end
        compared++; if (win !== 1'b0)       begin mismatched++; $display("FAIL midrst_win got %b want 0", win); end
        compared++; if (rd_select !== 8'h00) begin mismatched++; $display("FAIL midrst_rd_select got %h want 00", rd_select); end
        @(negedge clock);
        resetn = 1'b1;
        start_move(8'h75, 2'b01);
        wait_done();
        compared++; if (ok !== 1'b1 || cycles != 8) begin mismatched++; $display("FAIL midrst_rerun got done %b after %0d want 1 after 8", ok, cycles); end
        compared++; if (win !== 1'b1)  begin mismatched++; $display("FAIL midrst_rerun_win got %b want 1", win); end
    endtask

    initial begin
        clear_board();
        test_reset();
        test_row_win();
        test_invalid_player();
        test_edge_no_wrap();
        test_anti_diag();
        test_four_blocked();
        test_back_to_back();
        test_reset_mid_probe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
